// File: rtl/inert_intf_if.sv
// -----------------------------------------------------------------------------
// inert_intf_if
//   Bundles the gyro-facing signals of inert_intf: the data-ready interrupt,
//   the SPI monarch command/response handshake and the yaw-rate output.
//
//   INT      gyro data-ready interrupt (asynchronous, active-high)
//   wrt      one-cycle request for an SPI transaction
//   cmd      16-bit SPI command word, stable from wrt until done
//   done     one-cycle transaction-complete pulse from the SPI monarch
//   rd_data  16-bit SPI response, valid in the done cycle
//   yaw_rt   signed raw yaw rate
//   vld      one-cycle pulse, new yaw_rt available
//
//   modport master : the inert_intf side (drives wrt/cmd/yaw_rt/vld)
//   modport slave  : the environment side (drives INT/done/rd_data)
// -----------------------------------------------------------------------------
interface inert_intf_if;
  logic               INT;
  logic               wrt;
  logic [15:0]        cmd;
  logic               done;
  logic [15:0]        rd_data;
  logic signed [15:0] yaw_rt;
  logic               vld;

  modport master (
    input  INT,
    input  done,
    input  rd_data,
    output wrt,
    output cmd,
    output yaw_rt,
    output vld
  );

  modport slave (
    output INT,
    output done,
    output rd_data,
    input  wrt,
    input  cmd,
    input  yaw_rt,
    input  vld
  );
endinterface

// File: rtl/inert_intf.sv
// -----------------------------------------------------------------------------
// inert_intf
//   Gyro front end for the inertial integrator. After reset it waits for the
//   power-up timer to expire, programs the gyro with three configuration
//   writes, then waits for the data-ready interrupt. Each interrupt triggers
//   two SPI reads (yaw low byte, yaw high byte); the assembled signed word is
//   presented on yaw_rt together with a one-cycle vld pulse.
//
// Parameters
//   TMR_BITS   width of the power-up / watchdog timer (2^TMR_BITS cycles)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   bus        inert_intf_if.master: INT, wrt, cmd, done, rd_data, yaw_rt, vld
//
// Build option
//   INERT_WDOG_EN  when defined, the timer also runs while waiting for INT;
//                  if it reaches all-ones with no interrupt seen, the gyro is
//                  re-initialised (back to INIT1). When undefined the block
//                  waits for INT indefinitely.
// -----------------------------------------------------------------------------
module inert_intf #(
  parameter int TMR_BITS = 16
) (
  input  logic         clk,
  input  logic         rst,
  inert_intf_if.master bus
);

  localparam logic [15:0] CMD_INIT1 = 16'h0D02;
  localparam logic [15:0] CMD_INIT2 = 16'h1160;
  localparam logic [15:0] CMD_INIT3 = 16'h1440;
  localparam logic [15:0] CMD_RD_L  = 16'hA600;
  localparam logic [15:0] CMD_RD_H  = 16'hA700;

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    INIT1     = 3'd1,
    INIT2     = 3'd2,
    INIT3     = 3'd3,
    WAIT_INT  = 3'd4,
    RD_L      = 3'd5,
    RD_H      = 3'd6
  } state_t;

  state_t              state;
  state_t              nxt_state;
  logic [TMR_BITS-1:0] tmr;
  logic [TMR_BITS-1:0] nxt_tmr;
  logic                tmr_full;

  logic                int_meta_p0;
  logic                int_sync_p1;

  logic                wrt_q;
  logic [15:0]         cmd_q;
  logic                enter_cmd;
  logic                done_ok;
  logic                cap_lo;
  logic                cap_hi;

  logic [7:0]          lo_byte;
  logic signed [15:0]  yaw_q;
  logic                vld_q;

  // Command word issued on entry to each command state.
  function automatic logic [15:0] cmd_for(input state_t s);
    logic [15:0] c;
    case (s)
      INIT1:   c = CMD_INIT1;
      INIT2:   c = CMD_INIT2;
      INIT3:   c = CMD_INIT3;
      RD_L:    c = CMD_RD_L;
      RD_H:    c = CMD_RD_H;
      default: c = 16'h0000;
    endcase
    return c;
  endfunction

  function automatic logic is_cmd_state(input state_t s);
    return (s == INIT1) || (s == INIT2) || (s == INIT3) ||
           (s == RD_L)  || (s == RD_H);
  endfunction

  // --- Stage p0/p1: two-flop synchronizer for the asynchronous interrupt ---
  always_ff @(posedge clk) begin
    if (rst) begin
      int_meta_p0 <= 1'b0;
      int_sync_p1 <= 1'b0;
    end else begin
      int_meta_p0 <= bus.INT;
      int_sync_p1 <= int_meta_p0;
    end
  end

  assign tmr_full = &tmr;

  // wrt_q marks the first cycle in a command state; a done coincident with
  // it cannot belong to the transaction just requested, so it is dropped.
  assign done_ok = bus.done & ~wrt_q;

  // Next-state and timer logic.
  always_comb begin
    nxt_state = state;
    nxt_tmr   = tmr;
    case (state)
      INIT_WAIT: begin
        if (tmr_full) nxt_state = INIT1;
        else          nxt_tmr   = tmr + 1'b1;
      end
      INIT1:    if (done_ok) nxt_state = INIT2;
      INIT2:    if (done_ok) nxt_state = INIT3;
      INIT3:    if (done_ok) nxt_state = WAIT_INT;
      WAIT_INT: begin
        // The interrupt wins over a simultaneous watchdog expiry.
        if (int_sync_p1) begin
          nxt_state = RD_L;
        end
`ifdef INERT_WDOG_EN
        else if (tmr_full) begin
          nxt_state = INIT1;
        end else begin
          nxt_tmr = tmr + 1'b1;
        end
`endif
      end
      RD_L:     if (done_ok) nxt_state = RD_H;
      RD_H:     if (done_ok) nxt_state = WAIT_INT;
      default:  nxt_state = INIT_WAIT;
    endcase
`ifdef INERT_WDOG_EN
    // Watchdog window restarts every time WAIT_INT is entered.
    if ((nxt_state == WAIT_INT) && (state != WAIT_INT)) begin
      nxt_tmr = '0;
    end
`endif
  end

  // A transaction is requested only on a transition into a command state,
  // so wrt can never re-pulse while a state waits for its done.
  assign enter_cmd = (nxt_state != state) && is_cmd_state(nxt_state);

  assign cap_lo = (state == RD_L) && done_ok;
  assign cap_hi = (state == RD_H) && done_ok;

  // State register and SPI request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_WAIT;
      tmr   <= '0;
      wrt_q <= 1'b0;
      cmd_q <= 16'h0000;
    end else begin
      state <= nxt_state;
      tmr   <= nxt_tmr;
      wrt_q <= enter_cmd;
      if (enter_cmd) cmd_q <= cmd_for(nxt_state);
    end
  end

  // Yaw assembly: the low byte is staged separately so yaw_rt only ever
  // changes as a complete word, in the same edge that raises vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_byte <= 8'h00;
      yaw_q   <= 16'sh0000;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= cap_hi;
      if (cap_lo) lo_byte <= bus.rd_data[7:0];
      if (cap_hi) yaw_q   <= $signed({bus.rd_data[7:0], lo_byte});
    end
  end

  assign bus.wrt    = wrt_q;
  assign bus.cmd    = cmd_q;
  assign bus.yaw_rt = yaw_q;
  assign bus.vld    = vld_q;

endmodule

// File: tb/tb_inert_intf.sv
module tb_inert_intf;
  localparam int TMR_BITS = 4;
  localparam int TMR_CYC  = 1 << TMR_BITS;

  logic clk = 1'b0;
  logic rst;

  inert_intf_if bus();

  inert_intf #(.TMR_BITS(TMR_BITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        skip;   // never answer this transaction
    logic        early;  // also pulse a bogus done in the wrt cycle
    logic [15:0] data;
  } rsp_t;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          cyc      = 0;
  int          spur_req = 0;
  int          spur_ack = 0;
  int          viol     = 0;
  rsp_t        rsp_q[$];
  logic [15:0] cmd_q[$];
  int          wrt_cyc_q[$];
  logic [15:0] vld_q[$];
  int          vld_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // SPI monarch model: answers each wrt with done two cycles later.
  initial begin
    int   cnt;
    logic [15:0] pend;
    rsp_t r;
    cnt = 0;
    pend = 16'h0;
    bus.done = 1'b0;
    bus.rd_data = 16'h0;
    forever begin
      @(negedge clk);
      bus.done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.done = 1'b1;
          bus.rd_data = pend;
        end
      end
      if (spur_ack != spur_req) begin
        spur_ack++;
        bus.done = 1'b1;
        bus.rd_data = 16'($urandom);
      end
      if (bus.wrt === 1'b1) begin
        cmd_q.push_back(bus.cmd);
        wrt_cyc_q.push_back(cyc);
        if (rsp_q.size() > 0) r = rsp_q.pop_front();
        else r = '{skip: 1'b0, early: 1'b0, data: 16'($urandom)};
        if (!r.skip) begin
          cnt = 2;
          pend = r.data;
        end
        if (r.early) begin
          bus.done = 1'b1;
          bus.rd_data = 16'($urandom);
        end
      end
    end
  end

  // Output monitor: logs vld pulses and watches yaw_rt stability.
  initial begin
    logic [15:0] last_yaw;
    logic        prev_vld;
    last_yaw = 16'h0;
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        last_yaw = bus.yaw_rt;
        prev_vld = 1'b0;
      end else begin
        if (bus.vld === 1'b1) begin
          vld_q.push_back(bus.yaw_rt);
          vld_cyc_q.push_back(cyc);
          if (prev_vld) viol++;
        end else if (bus.yaw_rt !== last_yaw) begin
          viol++;
        end
        last_yaw = bus.yaw_rt;
        prev_vld = bus.vld;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.INT = 1'b0;
    tick(3);
    chk_cnt++;
    if (bus.wrt !== 1'b0) $display("FAIL reset_wrt: got %0b expected 0", bus.wrt); else pass_cnt++;
    chk_cnt++;
    if (bus.vld !== 1'b0) $display("FAIL reset_vld: got %0b expected 0", bus.vld); else pass_cnt++;
    chk_cnt++;
    if (bus.yaw_rt !== 16'h0000) $display("FAIL reset_yaw: got %h expected 0000", bus.yaw_rt); else pass_cnt++;
    chk_cnt++;
    if (bus.cmd !== 16'h0000) $display("FAIL reset_cmd: got %h expected 0000", bus.cmd); else pass_cnt++;
  endtask

  task automatic test_init();
    int rel;
    int b;
    b = cmd_q.size();
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    for (int i = 0; i < 100 && cmd_q.size() < b + 3; i++) tick(1);
    chk_cnt++;
    if (cmd_q.size() < b + 3) begin
      $display("FAIL init_timeout: got %0d writes expected 3", cmd_q.size() - b);
      return;
    end
    pass_cnt++;
    chk_cnt++;
    if (wrt_cyc_q[b] - rel !== TMR_CYC)
      $display("FAIL init_first_wrt_cycle: got %0d expected %0d", wrt_cyc_q[b] - rel, TMR_CYC);
    else pass_cnt++;
    chk_cnt++;
    if (cmd_q[b] !== 16'h0D02) $display("FAIL init1_cmd: got %h expected 0d02", cmd_q[b]); else pass_cnt++;
    chk_cnt++;
    if (cmd_q[b+1] !== 16'h1160) $display("FAIL init2_cmd: got %h expected 1160", cmd_q[b+1]); else pass_cnt++;
    chk_cnt++;
    if (cmd_q[b+2] !== 16'h1440) $display("FAIL init3_cmd: got %h expected 1440", cmd_q[b+2]); else pass_cnt++;
    tick(8);
    chk_cnt++;
    if (cmd_q.size() !== b + 3) $display("FAIL init_settle: got %0d writes expected 3", cmd_q.size() - b); else pass_cnt++;
    chk_cnt++;
    if (vld_q.size() !== 0) $display("FAIL init_no_vld: got %0d pulses expected 0", vld_q.size()); else pass_cnt++;
  endtask

  task automatic do_read(input logic [15:0] lo, input logic [15:0] hi, input logic early, input string tag);
    int b;
    int bv;
    int t0;
    logic [15:0] exp_yaw;
    exp_yaw = 16'((int'(hi) % 256) * 256 + (int'(lo) % 256));
    b  = cmd_q.size();
    bv = vld_q.size();
    rsp_q.push_back('{skip: 1'b0, early: early, data: lo});
    rsp_q.push_back('{skip: 1'b0, early: 1'b0, data: hi});
    @(negedge clk);
    bus.INT = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 20 && cmd_q.size() <= b; i++) tick(1);
    bus.INT = 1'b0;
    chk_cnt++;
    if (cmd_q.size() <= b) begin
      $display("FAIL %s_wrt_timeout: got no write expected RD_L", tag);
      rsp_q.delete();
      return;
    end
    pass_cnt++;
    chk_cnt++;
    if (wrt_cyc_q[b] - t0 !== 3)
      $display("FAIL %s_latency: got %0d expected 3", tag, wrt_cyc_q[b] - t0);
    else pass_cnt++;
    for (int i = 0; i < 30 && vld_q.size() <= bv; i++) tick(1);
    chk_cnt++;
    if (vld_q.size() <= bv || cmd_q.size() < b + 2) begin
      $display("FAIL %s_vld_timeout: got %0d pulses expected 1", tag, vld_q.size() - bv);
      return;
    end
    pass_cnt++;
    chk_cnt++;
    if (cmd_q[b] !== 16'hA600) $display("FAIL %s_rdl_cmd: got %h expected a600", tag, cmd_q[b]); else pass_cnt++;
    chk_cnt++;
    if (cmd_q[b+1] !== 16'hA700) $display("FAIL %s_rdh_cmd: got %h expected a700", tag, cmd_q[b+1]); else pass_cnt++;
    chk_cnt++;
    if (vld_q[bv] !== exp_yaw) $display("FAIL %s_yaw: got %h expected %h", tag, vld_q[bv], exp_yaw); else pass_cnt++;
    chk_cnt++;
    if (vld_cyc_q[bv] - wrt_cyc_q[b+1] !== 3)
      $display("FAIL %s_vld_timing: got %0d expected 3", tag, vld_cyc_q[bv] - wrt_cyc_q[b+1]);
    else pass_cnt++;
    tick(2);
    chk_cnt++;
    if (vld_q.size() !== bv + 1) $display("FAIL %s_single_vld: got %0d pulses expected 1", tag, vld_q.size() - bv); else pass_cnt++;
  endtask

  task automatic test_directed_reads();
    do_read(16'h0034, 16'h0012, 1'b0, "rd_1234");
    do_read(16'h0080, 16'h00FF, 1'b0, "rd_neg128");
    chk_cnt++;
    if ($signed(bus.yaw_rt) !== -16'sd128) $display("FAIL rd_neg128_signed: got %0d expected -128", $signed(bus.yaw_rt)); else pass_cnt++;
    do_read(16'h0001, 16'h0000, 1'b0, "rd_0001");
  endtask

  task automatic test_random_reads();
    for (int i = 0; i < 6; i++) begin
      do_read(16'($urandom), 16'($urandom), (i == 2), $sformatf("rnd%0d", i));
    end
  endtask

  task automatic test_spurious_done();
    int b;
    int bv;
    logic [15:0] y;
    b  = cmd_q.size();
    bv = vld_q.size();
    y  = bus.yaw_rt;
    spur_req++;
    tick(4);
    chk_cnt++;
    if (cmd_q.size() !== b) $display("FAIL spur_no_wrt: got %0d writes expected 0", cmd_q.size() - b); else pass_cnt++;
    chk_cnt++;
    if (vld_q.size() !== bv || bus.yaw_rt !== y)
      $display("FAIL spur_no_vld: got %0d pulses yaw %h expected 0 pulses yaw %h", vld_q.size() - bv, bus.yaw_rt, y);
    else pass_cnt++;
  endtask

  task automatic test_stability();
    chk_cnt++;
    if (viol !== 0) $display("FAIL yaw_stability: got %0d violations expected 0", viol); else pass_cnt++;
  endtask

  task automatic test_abort();
    int b;
    int bv;
    int rel;
    b  = cmd_q.size();
    bv = vld_q.size();
    rsp_q.push_back('{skip: 1'b0, early: 1'b0, data: 16'h0055});
    rsp_q.push_back('{skip: 1'b1, early: 1'b0, data: 16'h0066});
    @(negedge clk);
    bus.INT = 1'b1;
    for (int i = 0; i < 30 && cmd_q.size() < b + 2; i++) tick(1);
    bus.INT = 1'b0;
    chk_cnt++;
    if (cmd_q.size() < b + 2) begin
      $display("FAIL abort_reach_rdh: got %0d writes expected 2", cmd_q.size() - b);
      return;
    end
    pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    chk_cnt++;
    if (bus.yaw_rt !== 16'h0000 || bus.cmd !== 16'h0000 || bus.wrt !== 1'b0)
      $display("FAIL abort_reset_outputs: got yaw %h cmd %h wrt %0b expected 0000 0000 0", bus.yaw_rt, bus.cmd, bus.wrt);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    spur_req++;
    for (int i = 0; i < 100 && cmd_q.size() < b + 5; i++) tick(1);
    chk_cnt++;
    if (cmd_q.size() < b + 5) begin
      $display("FAIL abort_reinit_timeout: got %0d writes expected 3", cmd_q.size() - b - 2);
      return;
    end
    pass_cnt++;
    chk_cnt++;
    if (wrt_cyc_q[b+2] - rel !== TMR_CYC || cmd_q[b+2] !== 16'h0D02)
      $display("FAIL abort_reinit_wrt: got cycle %0d cmd %h expected cycle %0d cmd 0d02", wrt_cyc_q[b+2] - rel, cmd_q[b+2], TMR_CYC);
    else pass_cnt++;
    chk_cnt++;
    if (vld_q.size() !== bv || bus.yaw_rt !== 16'h0000)
      $display("FAIL abort_late_done: got %0d pulses yaw %h expected 0 pulses yaw 0000", vld_q.size() - bv, bus.yaw_rt);
    else pass_cnt++;
  endtask

  task automatic test_watchdog();
    int b;
    int w3;
    b  = cmd_q.size();
    w3 = wrt_cyc_q[b-1];
`ifdef INERT_WDOG_EN
    for (int i = 0; i < 100 && cmd_q.size() <= b; i++) tick(1);
    chk_cnt++;
    if (cmd_q.size() <= b) begin
      $display("FAIL wdog_timeout: got no write expected 0d02");
      return;
    end
    pass_cnt++;
    chk_cnt++;
    if (wrt_cyc_q[b] - w3 !== TMR_CYC + 3 || cmd_q[b] !== 16'h0D02)
      $display("FAIL wdog_reinit: got offset %0d cmd %h expected offset %0d cmd 0d02", wrt_cyc_q[b] - w3, cmd_q[b], TMR_CYC + 3);
    else pass_cnt++;
`else
    tick(1000);
    chk_cnt++;
    if (cmd_q.size() !== b) $display("FAIL wdog_disabled: got %0d writes expected 0", cmd_q.size() - b); else pass_cnt++;
    chk_cnt++;
    if (w3 <= 0) $display("FAIL wdog_prior_wrt: got cycle %0d expected positive", w3); else pass_cnt++;
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.INT = 1'b0;
    test_reset();
    test_init();
    test_directed_reads();
    test_random_reads();
    test_spurious_done();
    test_stability();
    test_abort();
    test_watchdog();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/inert_intf.md
INERT_INTF -- requirements
Module: inert_intf

Interface
REQ-001 Parameter: TMR_BITS, default 16, width of the power-up/watchdog timer (use 4 for fast sim).
REQ-002 Port: clk  input  1  system clock, all logic rising-edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: INT  input  1  gyro data-ready interrupt, asynchronous, active-high.
REQ-005 Port: wrt  output  1  one-cycle pulse requesting an SPI transaction.
REQ-006 Port: cmd  output  16  SPI command word, held stable from wrt until done.
REQ-007 Port: done  input  1  one-cycle pulse from SPI monarch, transaction complete.
REQ-008 Port: rd_data  input  16  SPI response, valid in the done cycle.
REQ-009 Port: yaw_rt  output  16  signed raw yaw rate, feeds inertial integrator.
REQ-010 Port: vld  output  1  one-cycle pulse, new yaw_rt available.

Function
REQ-011 INT SHALL be double-flopped before use; decisions use only the second flop (level-sensitive).
REQ-012 States SHALL be: INIT_WAIT, INIT1, INIT2, INIT3, WAIT_INT, RD_L, RD_H.
REQ-013 INIT_WAIT SHALL count the timer from 0 and go to INIT1 when the timer reaches all-ones (2^TMR_BITS cycles after reset release).
REQ-014 On entry to each of INIT1/INIT2/INIT3/RD_L/RD_H, wrt SHALL pulse high exactly one cycle (first cycle in state); cmd SHALL carry the state's command that same cycle.
REQ-015 Commands: INIT1 0x0D02, INIT2 0x1160, INIT3 0x1440, RD_L 0xA600, RD_H 0xA700.
REQ-016 Each command state SHALL hold until done: INIT1->INIT2->INIT3->WAIT_INT; RD_L->RD_H->WAIT_INT.
REQ-017 WAIT_INT SHALL go to RD_L in the cycle the synchronized INT is high.
REQ-018 On done in RD_L, rd_data[7:0] SHALL be captured as the low byte; upper rd_data bits ignored.
REQ-019 On done in RD_H, yaw_rt SHALL load {rd_data[7:0], low byte} on the next edge; vld SHALL be high exactly that following cycle.
REQ-020 yaw_rt SHALL hold its value between vld pulses; it SHALL never show a partially updated word.
REQ-021 done outside a command state, or in the wrt cycle, SHALL be ignored.
REQ-022 wrt SHALL never re-pulse within a state; at most one outstanding transaction.
REQ-023 Read-back latency: INT rise to wrt(RD_L) SHALL be 3 clock cycles (2 sync flops + state register).

Reset
REQ-024 With rst high at a clock edge: state=INIT_WAIT, timer=0, wrt=0, vld=0, yaw_rt=0x0000, low byte=0, INT sync flops=0, cmd=0x0000.
REQ-025 rst asserted mid-transaction SHALL abort it; after release the full init sequence SHALL repeat, and a late done SHALL be ignored.

Configuration
REQ-026 Macro INERT_WDOG_EN defined: the timer SHALL clear on entry to WAIT_INT and count there; reaching all-ones without synchronized INT SHALL move to INIT1 (re-init), with no vld.
REQ-027 INERT_WDOG_EN undefined: WAIT_INT SHALL wait indefinitely; timer used only in INIT_WAIT.

Verification (TMR_BITS=4)
REQ-028 Release rst, done returned 2 cycles after each wrt -> wrt at cycle 16 with cmd 0x0D02, then 0x1160, then 0x1440; state WAIT_INT; vld never high.
REQ-029 After init, INT high; rd_data 0x0034 then 0x0012 -> cmds 0xA600, 0xA700; vld one cycle with yaw_rt=0x1234.
REQ-030 Reads 0x0080 then 0x00FF -> yaw_rt=0xFF80 (-128); then reads 0x0001/0x0000 -> yaw_rt=0x0001; yaw_rt stable between pulses.
REQ-031 rst pulsed while in RD_H before done, done delivered after release -> done ignored, yaw_rt=0, wrt 0x0D02 again 16 cycles later.
REQ-032 INT held low after init: INERT_WDOG_EN defined -> wrt with cmd 0x0D02 after 16 cycles in WAIT_INT; undefined -> no wrt for 1000 cycles.
